tdm_receiver: RTL and testbench
===============================

Name: tdm_receiver

Overview:
- Downstream consumer of the 2-bit information selector (the SWI[7]-controlled A/B mux driving LED[7:6]).
- Takes the shared 2-bit line plus the selector bit, and demultiplexes symbols back into channels A and B.
- Reassembles each channel's symbols, MSB-first, into 8-bit words with per-channel framing timeout, error flags and word counters.
- Outputs feed LED/SEG/lcd debug signals in top.

Parameters:
- NSYM, 4, 2-bit symbols per assembled word (word width = 2*NSYM = 8).
- TIMEOUT, 16, idle cycles tolerated mid-word before the partial word is discarded.
- CNTW, 8, width of the per-channel word counters.

Ports:
- clk_2  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sel  input  1  source select of the upstream mux: 0 = channel A, 1 = channel B.
- sym_in  input  2  symbol on the shared line.
- sym_valid  input  1  symbol strobe; one symbol accepted per cycle when high.
- clr  input  1  synchronous clear of err flags and word counters.
- word_a  output  8  last completed channel-A word.
- word_b  output  8  last completed channel-B word.
- valid_a  output  1  one-cycle pulse when word_a is updated.
- valid_b  output  1  one-cycle pulse when word_b is updated.
- busy_a  output  1  channel-A partial word in progress.
- busy_b  output  1  channel-B partial word in progress.
- err_a  output  1  sticky channel-A timeout flag.
- err_b  output  1  sticky channel-B timeout flag.
- words_a  output  CNTW  completed channel-A words, modulo 2^CNTW.
- words_b  output  CNTW  completed channel-B words, modulo 2^CNTW.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-word):
  - All outputs and internal state go to 0: shift registers, symbol counts, timers, word_*, valid_*, busy_*, err_*, words_*.
  - Release is synchronous to the next clk_2 edge.
- Channel independence:
  - Each channel has its own shift register, symbol count (0..NSYM-1), idle timer, word counter and err flag.
  - Switching sel mid-word never disturbs the other channel's partial word.
- Per-channel FSM:
  - States: IDLE (count=0), COLLECT (count 1..NSYM-1).
  - busy_c = (state == COLLECT).
- Symbol acceptance: a symbol is accepted when sym_valid=1; the target channel is c = sel ? B : A.
  - shreg_c <= {shreg_c[5:0], sym_in}; count_c increments; timer_c <= 0.
  - IDLE -> COLLECT on the first symbol.
- Word completion (symbol accepted while count_c == NSYM-1):
  - word_c <= {shreg_c[5:0], sym_in}.
  - valid_c = 1 for exactly the next cycle.
  - count_c <= 0 (back to IDLE); words_c increments, wrapping 2^CNTW-1 -> 0.
  - word_c holds its value until the next completion.
- valid_c default is 0. Back-to-back completions on alternating channels are legal; each channel pulses independently.
- Timeout:
  - In COLLECT with no symbol accepted for c, timer_c increments each cycle.
  - At the edge where timer_c == TIMEOUT-1 and still no symbol arrives: partial word discarded (shreg_c=0, count_c=0, timer_c=0 -> IDLE) and err_c <= 1.
  - word_c, words_c and valid_c are unaffected.
  - A symbol for c arriving in the cycle with timer_c == TIMEOUT-1 is accepted normally, with no abort.
  - Timer is inactive (held 0) in IDLE.
- clr:
  - Clears err_a, err_b, words_a and words_b at the next edge.
  - Does not touch partial words, word_* or busy_*.
  - If clr coincides with a timeout on c, err_c ends at 1 (set wins).
  - If clr coincides with a completion on c, words_c ends at 1.
- Latency: word_c and valid_c are registered and appear one edge after the last symbol's sampling edge.

Test Plan:
- Single word: reset, sel=0; sym_in 10, 01, 11, 00 with sym_valid=1 on 4 consecutive cycles -> word_a=0x9C, valid_a high exactly 1 cycle, words_a=1, busy_a 1 then 0, channel B untouched (word_b=0).
- Interleaved: sel toggles A,B,A,B,… each cycle with symbols A:11,00,01,10 and B:01,10,11,00 -> word_a=0xC6 (pulse after 7th symbol), word_b=0x6C (pulse after 8th), words_a=words_b=1.
- Timeout and recovery:
  - 2 symbols to A, then 16 idle cycles -> err_a=1, busy_a=0, words_a unchanged.
  - Then 01 x4 -> word_a=0x55, err_a still 1 until clr.
  - Repeat with the 3rd symbol on idle cycle 16 -> no error.
- Counter wrap and clr: 256 complete words on B -> words_b=0. Then clr asserted in the same cycle as an A timeout -> err_a=1, words_a=0.
- Reset mid-word: 3 symbols on A, pulse reset low for half a cycle (asynchronously) -> all outputs 0 immediately. Then 4 symbols 11 -> word_a=0xFF, words_a=1.
- Channel switch mid-word: 2 symbols to A (10, 10), 4 to B (00 x4), 2 more to A (01, 01) -> word_b=0x00 and word_a=0xA5, with no error on either channel.

Source files
------------

// File: rtl/tdm_receiver.sv
// tdm_receiver: splits the shared 2-bit symbol line into channels A and B
// by the upstream selector bit. Each channel packs its symbols MSB-first
// into words of 2*NSYM bits. Each channel also keeps a mid-word idle timeout,
// a sticky error flag and a completed-word counter.
//
// Handshake: a symbol is transferred on every rising clk_2 edge where
// sym_valid is high. There is no backpressure. The symbol belongs to channel
// B when sel is 1, and to channel A otherwise. valid_a/valid_b are
// single-cycle strobes that come out one edge after the completing symbol
// is sampled.
module tdm_receiver #(
  parameter int NSYM    = 4,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 8
) (
  input  logic            clk_2,
  input  logic            reset,
  input  logic            sel,
  input  logic [1:0]      sym_in,
  input  logic            sym_valid,
  input  logic            clr,
  output logic [7:0]      word_a,
  output logic [7:0]      word_b,
  output logic            valid_a,
  output logic            valid_b,
  output logic            busy_a,
  output logic            busy_b,
  output logic            err_a,
  output logic            err_b,
  output logic [CNTW-1:0] words_a,
  output logic [CNTW-1:0] words_b
);

  localparam int WW = 2 * NSYM;               // assembled word width
  localparam int CW = (NSYM > 2) ? $clog2(NSYM) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  // Per-channel state. The state is visible outside as busy_c, which is
  // high exactly when the channel is in S_COLLECT.
  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } ch_state_e;

  logic [WW-1:0]   w_word  [2];
  logic            w_valid [2];
  logic            w_busy  [2];
  logic            w_err   [2];
  logic [CNTW-1:0] w_words [2];

  for (genvar g = 0; g < 2; g++) begin : gen_ch
    localparam logic CH_SEL = (g == 1);

    ch_state_e       r_state, w_state_nxt;
    // Only the low WW-2 bits of the shift register are ever read, so only
    // those bits are stored.
    logic [WW-3:0]   r_shreg, w_shreg_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [TW-1:0]   r_timer, w_timer_nxt;
    logic [WW-1:0]   r_word;
    logic            r_valid;
    logic            r_err;
    logic [CNTW-1:0] r_words;

    logic            w_hit;
    logic [WW-1:0]   w_shifted;
    logic            w_complete;
    logic            w_timeout;

    assign w_hit     = sym_valid && (sel == CH_SEL);
    assign w_shifted = {r_shreg, sym_in};

    // FSM state register plus the datapath that goes with it
    always_ff @(posedge clk_2 or negedge reset) begin
      if (!reset) begin
        r_state <= S_IDLE;
        r_shreg <= '0;
        r_count <= '0;
        r_timer <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_shreg <= w_shreg_nxt;
        r_count <= w_count_nxt;
        r_timer <= w_timer_nxt;
      end
    end

    // Next state: collect symbols, finish a word, or abort on idle timeout
    always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_count_nxt = r_count;
      w_timer_nxt = r_timer;
      w_complete  = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
        S_IDLE: begin
          w_timer_nxt = '0;
          if (w_hit) begin
            w_shreg_nxt = w_shifted[WW-3:0];
            w_count_nxt = CW'(1);
            w_state_nxt = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_hit) begin
            w_shreg_nxt = w_shifted[WW-3:0];
            w_timer_nxt = '0;
            if (r_count == CW'(NSYM - 1)) begin
              w_count_nxt = '0;
              w_complete  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_count_nxt = r_count + CW'(1);
            end
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            // A symbol in this same cycle would have been taken above
            w_shreg_nxt = '0;
            w_count_nxt = '0;
            w_timer_nxt = '0;
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_shreg_nxt = '0;
          w_count_nxt = '0;
          w_timer_nxt = '0;
        end
      endcase
    end

    // Word output, completion strobe, sticky error and word counter.
    // When clr and an event on this channel happen in the same cycle,
    // the event wins.
    always_ff @(posedge clk_2 or negedge reset) begin
      if (!reset) begin
        r_word  <= '0;
        r_valid <= 1'b0;
        r_err   <= 1'b0;
        r_words <= '0;
      end else begin
        r_valid <= w_complete;
        if (w_complete) begin
          r_word <= w_shifted;
        end
        if (w_timeout) begin
          r_err <= 1'b1;
        end else if (clr) begin
          r_err <= 1'b0;
        end
        if (w_complete) begin
          r_words <= clr ? CNTW'(1) : r_words + CNTW'(1);
        end else if (clr) begin
          r_words <= '0;
        end
      end
    end

    assign w_word[g]  = r_word;
    assign w_valid[g] = r_valid;
    assign w_busy[g]  = (r_state == S_COLLECT);
    assign w_err[g]   = r_err;
    assign w_words[g] = r_words;
  end

  assign word_a  = w_word[0];
  assign word_b  = w_word[1];
  assign valid_a = w_valid[0];
  assign valid_b = w_valid[1];
  assign busy_a  = w_busy[0];
  assign busy_b  = w_busy[1];
  assign err_a   = w_err[0];
  assign err_b   = w_err[1];
  assign words_a = w_words[0];
  assign words_b = w_words[1];

endmodule

// File: tb/tb_tdm_receiver.sv
// Directed testbench for tdm_receiver. Inputs change 1 time unit after each
// rising edge. Outputs are sampled at that same point, which is well away
// from the next active edge.
module tb_tdm_receiver;

  logic       clk_2;
  logic       reset;
  logic       sel;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       clr;
  logic [7:0] word_a, word_b;
  logic       valid_a, valid_b, busy_a, busy_b, err_a, err_b;
  logic [7:0] words_a, words_b;

  int checks = 0;
  int errors = 0;

  tdm_receiver #(.NSYM(4), .TIMEOUT(16), .CNTW(8)) dut (
    .clk_2(clk_2), .reset(reset), .sel(sel), .sym_in(sym_in),
    .sym_valid(sym_valid), .clr(clr),
    .word_a(word_a), .word_b(word_b), .valid_a(valid_a), .valid_b(valid_b),
    .busy_a(busy_a), .busy_b(busy_b), .err_a(err_a), .err_b(err_b),
    .words_a(words_a), .words_b(words_b)
  );

  // Clock
  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Advance one edge; leave time at edge + 1
  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic idle(input int n);
    sym_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic c, input logic [1:0] s);
    sel = c; sym_in = s; sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; sel = 1'b0; sym_in = 2'b00; sym_valid = 1'b0; clr = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    #1;
    checks++; if ({word_a, word_b, words_a, words_b} !== 32'h0) begin errors++;
      $display("FAIL reset_words: got %h required 00000000", {word_a, word_b, words_a, words_b}); end
    checks++; if ({valid_a, valid_b, busy_a, busy_b, err_a, err_b} !== 6'b0) begin errors++;
      $display("FAIL reset_flags: got %b required 000000", {valid_a, valid_b, busy_a, busy_b, err_a, err_b}); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_single_word();
    do_reset();
    send(0, 2'b10);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_first: got %b required 1", busy_a); end
    send(0, 2'b01); send(0, 2'b11); send(0, 2'b00);
    checks++; if (word_a !== 8'h9C) begin errors++; $display("FAIL single_word_a: got %h required 9c", word_a); end
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL single_valid_a: got %b required 1", valid_a); end
    checks++; if (words_a !== 8'd1) begin errors++; $display("FAIL single_words_a: got %0d required 1", words_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b required 0", busy_a); end
    checks++; if ({word_b, valid_b, busy_b} !== 10'h0) begin errors++; $display("FAIL single_b_untouched: got %h required 000", {word_b, valid_b, busy_b}); end
    idle(1);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL single_valid_pulse: got %b required 0", valid_a); end
    checks++; if (word_a !== 8'h9C) begin errors++; $display("FAIL single_word_hold: got %h required 9c", word_a); end
  endtask

  task automatic test_interleaved();
    logic [1:0] sa [4];
    logic [1:0] sb [4];
    sa[0] = 2'b11; sa[1] = 2'b00; sa[2] = 2'b01; sa[3] = 2'b10;
    sb[0] = 2'b01; sb[1] = 2'b10; sb[2] = 2'b11; sb[3] = 2'b00;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(0, sa[i]); send(1, sb[i]);
    end
    send(0, sa[3]);
    checks++; if ({valid_a, valid_b} !== 2'b10) begin errors++; $display("FAIL inter_pulse7: got %b required 10", {valid_a, valid_b}); end
    checks++; if (word_a !== 8'hC6) begin errors++; $display("FAIL inter_word_a: got %h required c6", word_a); end
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL inter_busy_b: got %b required 1", busy_b); end
    send(1, sb[3]);
    checks++; if ({valid_a, valid_b} !== 2'b01) begin errors++; $display("FAIL inter_pulse8: got %b required 01", {valid_a, valid_b}); end
    checks++; if (word_b !== 8'h6C) begin errors++; $display("FAIL inter_word_b: got %h required 6c", word_b); end
    checks++; if ({words_a, words_b} !== 16'h0101) begin errors++; $display("FAIL inter_counts: got %h required 0101", {words_a, words_b}); end
  endtask

  task automatic test_timeout();
    do_reset();
    send(0, 2'b10); send(0, 2'b11);
    idle(15);
    checks++; if ({busy_a, err_a} !== 2'b10) begin errors++; $display("FAIL tmo_before: got %b required 10", {busy_a, err_a}); end
    idle(1);
    checks++; if ({busy_a, err_a} !== 2'b01) begin errors++; $display("FAIL tmo_abort: got %b required 01", {busy_a, err_a}); end
    checks++; if ({words_a, word_a, valid_a} !== 17'h0) begin errors++; $display("FAIL tmo_unaffected: got %h required 0", {words_a, word_a, valid_a}); end
    for (int i = 0; i < 4; i++) send(0, 2'b01);
    checks++; if (word_a !== 8'h55) begin errors++; $display("FAIL tmo_recover_word: got %h required 55", word_a); end
    checks++; if ({err_a, words_a} !== 9'h101) begin errors++; $display("FAIL tmo_err_sticky: got %h required 101", {err_a, words_a}); end
    clr = 1'b1; step(); clr = 1'b0;
    checks++; if ({err_a, words_a, word_a} !== 17'h00055) begin errors++; $display("FAIL tmo_clr: got %h required 00055", {err_a, words_a, word_a}); end
    // third symbol lands on the cycle where the timer is at its limit
    send(0, 2'b11); send(0, 2'b10);
    idle(15);
    send(0, 2'b01);
    checks++; if ({busy_a, err_a} !== 2'b10) begin errors++; $display("FAIL tmo_edge_accept: got %b required 10", {busy_a, err_a}); end
    send(0, 2'b00);
    checks++; if (word_a !== 8'hE4) begin errors++; $display("FAIL tmo_edge_word: got %h required e4", word_a); end
    checks++; if ({err_a, valid_a, words_a} !== 10'h101) begin errors++; $display("FAIL tmo_edge_flags: got %h required 101", {err_a, valid_a, words_a}); end
  endtask

  task automatic test_wrap_clr();
    do_reset();
    for (int w = 0; w < 255; w++)
      for (int i = 0; i < 4; i++) send(1, 2'b10);
    checks++; if (words_b !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d required 255", words_b); end
    for (int i = 0; i < 4; i++) send(1, 2'b10);
    checks++; if (words_b !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d required 0", words_b); end
    checks++; if ({word_b, valid_b, err_b} !== 10'b1010101010) begin errors++; $display("FAIL wrap_word_b: got %h required 2aa", {word_b, valid_b, err_b}); end
    for (int i = 0; i < 4; i++) send(1, 2'b01);
    for (int i = 0; i < 4; i++) send(0, 2'b11);
    checks++; if ({words_a, words_b} !== 16'h0101) begin errors++; $display("FAIL wrap_pre_counts: got %h required 0101", {words_a, words_b}); end
    // clr together with a completion on A
    send(0, 2'b00); send(0, 2'b01); send(0, 2'b10);
    clr = 1'b1; send(0, 2'b11); clr = 1'b0;
    checks++; if ({words_a, words_b} !== 16'h0100) begin errors++; $display("FAIL clr_with_done: got %h required 0100", {words_a, words_b}); end
    checks++; if (word_a !== 8'h1B) begin errors++; $display("FAIL clr_done_word: got %h required 1b", word_a); end
    // clr together with a timeout on A
    send(0, 2'b11); send(0, 2'b11);
    idle(15);
    clr = 1'b1; step(); clr = 1'b0;
    checks++; if ({err_a, words_a, busy_a} !== 10'b1000000000) begin errors++; $display("FAIL clr_with_tmo: got %b required 1000000000", {err_a, words_a, busy_a}); end
    checks++; if (word_a !== 8'h1B) begin errors++; $display("FAIL clr_tmo_word: got %h required 1b", word_a); end
  endtask

  task automatic test_reset_midword();
    do_reset();
    for (int i = 0; i < 4; i++) send(0, 2'b10);
    for (int i = 0; i < 4; i++) send(1, 2'b01);
    send(0, 2'b11); send(0, 2'b11); send(0, 2'b11);
    reset = 1'b0;
    #2;
    checks++; if ({word_a, word_b, words_a, words_b} !== 32'h0) begin errors++; $display("FAIL midrst_words: got %h required 0", {word_a, word_b, words_a, words_b}); end
    checks++; if ({valid_a, valid_b, busy_a, busy_b, err_a, err_b} !== 6'b0) begin errors++; $display("FAIL midrst_flags: got %b required 000000", {valid_a, valid_b, busy_a, busy_b, err_a, err_b}); end
    #3;
    reset = 1'b1;
    send(0, 2'b11); send(0, 2'b11); send(0, 2'b11);
    checks++; if ({valid_a, busy_a, words_a} !== 10'b0100000000) begin errors++; $display("FAIL midrst_restart: got %b required 0100000000", {valid_a, busy_a, words_a}); end
    send(0, 2'b11);
    checks++; if ({word_a, words_a} !== 16'hFF01) begin errors++; $display("FAIL midrst_word: got %h required ff01", {word_a, words_a}); end
  endtask

  task automatic test_channel_switch();
    do_reset();
    send(0, 2'b10); send(0, 2'b10);
    send(1, 2'b00); send(1, 2'b00); send(1, 2'b00); send(1, 2'b00);
    checks++; if ({valid_b, busy_a, busy_b, words_b} !== 11'b11000000001) begin errors++; $display("FAIL sw_b_done: got %b required 11000000001", {valid_b, busy_a, busy_b, words_b}); end
    send(0, 2'b01); send(0, 2'b01);
    checks++; if ({word_a, word_b} !== 16'hA500) begin errors++; $display("FAIL sw_words: got %h required a500", {word_a, word_b}); end
    checks++; if ({valid_a, err_a, err_b, words_a} !== 11'b10000000001) begin errors++; $display("FAIL sw_flags: got %b required 10000000001", {valid_a, err_a, err_b, words_a}); end
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0; sym_in = 2'b00; sym_valid = 1'b0; clr = 1'b0;
    test_reset();
    test_single_word();
    test_interleaved();
    test_timeout();
    test_wrap_clr();
    test_reset_midword();
    test_channel_switch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
